// File: rtl/wave_pkg.sv
// wave_pkg: shared state encoding and trigger-mode constants for wave_capture
package wave_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DRAIN     = 2'd3
  } wave_state_e;
  localparam logic [1:0] TRIG_IMM  = 2'b00;
  localparam logic [1:0] TRIG_RISE = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;
  localparam logic [1:0] TRIG_ANY  = 2'b11;
endpackage

// File: rtl/wave_tick_gen.sv
// wave_tick_gen: down-counting prescaler, one tick every presc+1 cycles
module wave_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] presc,
  output logic       tick
);
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    tick  = !load && cnt_q == 8'd0;
    cnt_d = (load || tick) ? presc : cnt_q - 8'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/wave_capture.sv
// wave_capture: triggered sample capture, drained channel by channel as MSB-first pixel bytes
module wave_capture
  import wave_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CH    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sample_in,
  input  logic [7:0]    cfg_presc,
  input  logic [2:0]    cfg_trig_ch,
  input  logic [1:0]    cfg_trig_mode,
  input  logic          arm,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic [1:0]    state_o
);
  localparam int BPC = DEPTH / 8;
  localparam int IW  = $clog2(DEPTH);
  localparam int BW  = BPC > 1 ? $clog2(BPC) : 1;
  localparam int CW  = CH > 1 ? $clog2(CH) : 1;
  wave_state_e   state_q, state_d;
  logic [7:0]    presc_q, presc_d;
  logic [2:0]    trig_ch_q, trig_ch_d;
  logic [1:0]    trig_mode_q, trig_mode_d;
  logic          prev_q, prev_d, primed_q, primed_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [CH-1:0] buf_q [DEPTH];
  logic [CH-1:0] buf_d [DEPTH];
  logic          load, tick, wr_en, lvl, edge_hit, last_byte;
  logic [7:0]    byte_v;
  wave_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .presc (load ? cfg_presc : presc_q),
    .tick  (tick)
  );
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    trig_ch_d   = trig_ch_q;
    trig_mode_d = trig_mode_q;
    prev_d      = prev_q;
    primed_d    = primed_q;
    idx_d       = idx_q;
    ch_d        = ch_q;
    byte_d      = byte_q;
    load        = 1'b0;
    wr_en       = 1'b0;
    lvl         = sample_in[trig_ch_q];
    last_byte   = ch_q == CW'(CH - 1) && byte_q == BW'(BPC - 1);
    // the first tick after arming only primes prev, so stale levels never trigger
    edge_hit    = primed_q && (trig_mode_q == TRIG_RISE ? !prev_q && lvl :
                               trig_mode_q == TRIG_FALL ? prev_q && !lvl : prev_q != lvl);
    case (state_q)
      IDLE: if (arm) begin
        state_d     = WAIT_TRIG;
        presc_d     = cfg_presc;
        trig_ch_d   = cfg_trig_ch;
        trig_mode_d = cfg_trig_mode;
        primed_d    = 1'b0;
        idx_d       = '0;
        load        = 1'b1;
      end
      WAIT_TRIG: if (tick) begin
        prev_d   = lvl;
        primed_d = 1'b1;
        if (trig_mode_q == TRIG_IMM || edge_hit) begin
          wr_en   = 1'b1;
          idx_d   = idx_q + IW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: if (tick) begin
        wr_en = 1'b1;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = DRAIN;
          ch_d    = '0;
          byte_d  = '0;
        end
      end
      DRAIN: if (out_ready) begin
        state_d = last_byte ? IDLE : DRAIN;
        byte_d  = byte_q == BW'(BPC - 1) ? '0 : byte_q + BW'(1);
        ch_d    = byte_q == BW'(BPC - 1) ? ch_q + CW'(1) : ch_q;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end
  always_comb begin
    buf_d = buf_q;
    if (wr_en) buf_d[idx_q] = sample_in;
    byte_v = 8'h00;
    for (int s = 0; s < DEPTH; s++)
      if (BW'(s / 8) == byte_q) byte_v[7 - (s % 8)] = buf_q[s][ch_q];
  end
  assign out_valid = state_q == DRAIN;
  assign out_last  = out_valid && last_byte;
  assign out_data  = out_valid ? byte_v : 8'h00;
  assign state_o   = state_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= 8'd0;
      trig_ch_q   <= 3'd0;
      trig_mode_q <= TRIG_IMM;
      prev_q      <= 1'b0;
      primed_q    <= 1'b0;
      idx_q       <= '0;
      ch_q        <= '0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      trig_ch_q   <= trig_ch_d;
      trig_mode_q <= trig_mode_d;
      prev_q      <= prev_d;
      primed_q    <= primed_d;
      idx_q       <= idx_d;
      ch_q        <= ch_d;
      byte_q      <= byte_d;
    end
  always_ff @(posedge clk) buf_q <= buf_d;
endmodule
